// File: rtl/shift_add_multiplier_8bit_pkg.sv
// Shared constants and FSM encoding for the shift-and-add multiplier.
package shift_add_multiplier_8bit_pkg;

  localparam int MUL_WIDTH = 8;

  typedef enum logic [1:0] {
    MUL_ST_IDLE = 2'd0,
    MUL_ST_CALC = 2'd1,
    MUL_ST_DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/shift_add_multiplier_8bit_adder.sv
// 8-bit ripple-carry adder used as the per-step accumulator adder.
module ripple_adder_8bit (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic       cin_i,
  output logic [7:0] sum_o,
  output logic       cout_o
);

  logic [8:0] carry;

  assign carry[0] = cin_i;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_fa
      assign sum_o[gi]   = a_i[gi] ^ b_i[gi] ^ carry[gi];
      assign carry[gi+1] = (a_i[gi] & b_i[gi]) | (carry[gi] & (a_i[gi] ^ b_i[gi]));
    end
  endgenerate

  assign cout_o = carry[8];

endmodule

// File: rtl/shift_add_multiplier_8bit.sv
// Multi-cycle unsigned 8x8 -> 16 shift-and-add multiplier with valid/ready handshakes.
// Optional overflow flag output enabled by defining MUL_OVF_FLAG_EN.
module shift_add_multiplier_8bit
  import shift_add_multiplier_8bit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
`ifdef MUL_OVF_FLAG_EN
  output logic               ovf,
`endif
  output logic [2*WIDTH-1:0] product
);

  generate
    if (WIDTH != MUL_WIDTH) begin : g_bad_width
      $error("shift_add_multiplier_8bit: WIDTH must be 8");
    end
    if ((1 << CNT_W) <= WIDTH) begin : g_bad_cnt
      $error("shift_add_multiplier_8bit: CNT_W too narrow for WIDTH");
    end
  endgenerate

  mul_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [WIDTH-1:0] acc_q,   acc_d;
  logic [WIDTH-1:0] mq_q,    mq_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;

  logic [WIDTH-1:0] add_b;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;

  assign add_b = mq_q[0] ? mcand_q : '0;

  ripple_adder_8bit u_step_adder (
    .a_i    (acc_q),
    .b_i    (add_b),
    .cin_i  (1'b0),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mq_d    = mq_q;
    mcand_d = mcand_q;
    case (state_q)
      MUL_ST_IDLE: begin
        if (in_valid) begin
          mcand_d = a;
          mq_d    = b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = MUL_ST_CALC;
        end
      end
      MUL_ST_CALC: begin
        // 17-bit {carry, sum, mq} shifted right by one; mq[0] falls off.
        {acc_d, mq_d} = {add_cout, add_sum, mq_q[WIDTH-1:1]};
        cnt_d         = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = MUL_ST_DONE;
        end
      end
      MUL_ST_DONE: begin
        if (out_ready) begin
          state_d = MUL_ST_IDLE;
        end
      end
      default: state_d = MUL_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= MUL_ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mq_q    <= '0;
      mcand_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mq_q    <= mq_d;
      mcand_q <= mcand_d;
    end
  end

  assign in_ready  = (state_q == MUL_ST_IDLE);
  assign out_valid = (state_q == MUL_ST_DONE);
  assign product   = {acc_q, mq_q};

`ifdef MUL_OVF_FLAG_EN
  assign ovf = (state_q == MUL_ST_DONE) && (|acc_q);
`endif

endmodule

// File: tb/tb_shift_add_multiplier_8bit.sv
// Scoreboard bench: stimulus pushes hand-computed results, a monitor pops on out_valid.
module tb_shift_add_multiplier_8bit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;
`ifdef MUL_OVF_FLAG_EN
  logic        ovf;
`endif

  shift_add_multiplier_8bit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef MUL_OVF_FLAG_EN
    .ovf       (ovf),
`endif
    .product   (product)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] prod;
    logic        ovf;
    int          acc_cyc;
  } exp_t;

  exp_t sb_q[$];
  int   cyc          = 0;
  int   tests_run    = 0;
  int   tests_failed = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end else begin
      $display("[TB] ok   %s: 0x%0h (cycle %0d)", name, act, cyc);
    end
  endtask

  // Monitor: first cycle of out_valid pops and checks; later valid cycles check the hold.
  initial begin : monitor
    exp_t cur;
    logic prev_valid;
    prev_valid = 1'b0;
    cur = '{prod: 16'h0, ovf: 1'b0, acc_cyc: 0};
    forever begin
      @(negedge clk);
      if (rst_n && out_valid) begin
        if (!prev_valid) begin
          if (sb_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL unexpected_out_valid: got product 0x%0h, required no output", product);
          end else begin
            cur = sb_q.pop_front();
            check("product", 32'(product), 32'(cur.prod));
            check("latency", 32'(cyc - cur.acc_cyc), 32'd8);
`ifdef MUL_OVF_FLAG_EN
            check("ovf", 32'(ovf), 32'(cur.ovf));
`endif
          end
        end else begin
          check("product_hold", 32'(product), 32'(cur.prod));
        end
      end
      prev_valid = rst_n && out_valid;
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) check("out_valid_timeout", 32'(out_valid), 32'd1);
  endtask

  // Called at a negedge; holds in_valid for exactly one rising edge.
  task automatic issue(input logic [7:0] av, input logic [7:0] bv,
                       input logic [15:0] exp_p, input logic exp_o, input logic push);
    wait_ready();
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    if (push) sb_q.push_back('{prod: exp_p, ovf: exp_o, acc_cyc: cyc + 1});
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin : stimulus
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = 8'h00;
    b         = 8'h00;
    out_ready = 1'b1;
    idle_cycles(2);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_product", 32'(product), 32'd0);
`ifdef MUL_OVF_FLAG_EN
    check("reset_ovf", 32'(ovf), 32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    issue(8'd0,   8'd0,   16'h0000, 1'b0, 1'b1);
    issue(8'd13,  8'd11,  16'h008F, 1'b0, 1'b1);
    issue(8'd255, 8'd255, 16'hFE01, 1'b1, 1'b1);
    issue(8'd128, 8'd2,   16'h0100, 1'b1, 1'b1);
    issue(8'd1,   8'd255, 16'h00FF, 1'b0, 1'b1);

    // Back-pressure with stray in_valid pulses during CALC and DONE.
    wait_ready();
    out_ready = 1'b0;
    issue(8'd7, 8'd9, 16'h003F, 1'b0, 1'b1);
    a = 8'd1;
    b = 8'd1;
    in_valid = 1'b1;
    idle_cycles(2);
    in_valid = 1'b0;
    wait_valid();
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    check("bp_release_out_valid", 32'(out_valid), 32'd0);

    // Reset at CALC step 4 of 200*3; nothing may come out.
    issue(8'd200, 8'd3, 16'h0258, 1'b0, 1'b0);
    idle_cycles(3);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_product", 32'(product), 32'd0);
    idle_cycles(12);
    issue(8'd3, 8'd5, 16'h000F, 1'b0, 1'b1);

    begin
      int n = 0;
      while (sb_q.size() != 0 && n < 60) begin
        @(negedge clk);
        n++;
      end
    end
    idle_cycles(2);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
